// File: rtl/rs_syndrome_ctrl.sv
// Reed-Solomon GF(2^4) syndrome calculator: Horner-evaluates S1..S4 = r(alpha^j)
// over one codeword, then holds the result until the consumer takes it.
module rs_syndrome_ctrl #(
  parameter int N = 15
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       sink_valid,
  output logic       sink_ready,
  input  logic [3:0] sink_data,
  input  logic       sink_last,
  output logic       source_valid,
  input  logic       source_ready,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic [3:0] s3,
  output logic [3:0] s4,
  output logic       source_nonzero,
  output logic       source_framing_err
);

  typedef enum logic {RUN = 1'b0, OUT = 1'b1} state_e;

  localparam logic [3:0] LAST_CNT = 4'(N - 1);

  state_e     state_q, state_d;
  logic [3:0] s1_q, s2_q, s3_q, s4_q;
  logic [3:0] s1_d, s2_d, s3_d, s4_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ferr_q, ferr_d;
  logic       accept;
  logic       cw_end;

  // Multiply by alpha under x^4+x+1: shift, fold the carry back in as x+1.
  function automatic logic [3:0] mul_a1(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] mul_a2(input logic [3:0] x);
    return mul_a1(mul_a1(x));
  endfunction

  function automatic logic [3:0] mul_a3(input logic [3:0] x);
    return mul_a1(mul_a2(x));
  endfunction

  function automatic logic [3:0] mul_a4(input logic [3:0] x);
    return mul_a2(mul_a2(x));
  endfunction

  assign accept = sink_valid && (state_q == RUN);
  assign cw_end = accept && (sink_last || (cnt_q == LAST_CNT));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cw_end) state_d = OUT;
      OUT:     if (source_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    sink_ready   = (state_q == RUN) && !sys_rst;
    source_valid = (state_q == OUT) && !sys_rst;
  end

  always_comb begin
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    s4_d   = s4_q;
    cnt_d  = cnt_q;
    ferr_d = ferr_q;
    if (accept) begin
      s1_d  = mul_a1(s1_q) ^ sink_data;
      s2_d  = mul_a2(s2_q) ^ sink_data;
      s3_d  = mul_a3(s3_q) ^ sink_data;
      s4_d  = mul_a4(s4_q) ^ sink_data;
      cnt_d = cnt_q + 4'd1;
      // Length is wrong whenever "last" and "counter full" disagree.
      if (cw_end) ferr_d = sink_last ^ (cnt_q == LAST_CNT);
    end else if ((state_q == OUT) && source_ready) begin
      s1_d   = 4'h0;
      s2_d   = 4'h0;
      s3_d   = 4'h0;
      s4_d   = 4'h0;
      cnt_d  = 4'h0;
      ferr_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_q   <= 4'h0;
      s2_q   <= 4'h0;
      s3_q   <= 4'h0;
      s4_q   <= 4'h0;
      cnt_q  <= 4'h0;
      ferr_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      s4_q   <= s4_d;
      cnt_q  <= cnt_d;
      ferr_q <= ferr_d;
    end
  end

  assign s1                 = s1_q;
  assign s2                 = s2_q;
  assign s3                 = s3_q;
  assign s4                 = s4_q;
  assign source_nonzero     = |{s1_q, s2_q, s3_q, s4_q};
  assign source_framing_err = ferr_q;

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Bench for rs_syndrome_ctrl: directed vector table, multi-cycle corner sequences,
// and random codewords checked against a direct polynomial-evaluation model.
module tb_rs_syndrome_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       sink_valid;
  logic       sink_ready;
  logic [3:0] sink_data;
  logic       sink_last;
  logic       source_valid;
  logic       source_ready;
  logic [3:0] s1, s2, s3, s4;
  logic       source_nonzero;
  logic       source_framing_err;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  rs_syndrome_ctrl #(.N(15)) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .sink_valid        (sink_valid),
    .sink_ready        (sink_ready),
    .sink_data         (sink_data),
    .sink_last         (sink_last),
    .source_valid      (source_valid),
    .source_ready      (source_ready),
    .s1                (s1),
    .s2                (s2),
    .s3                (s3),
    .s4                (s4),
    .source_nonzero    (source_nonzero),
    .source_framing_err(source_framing_err)
  );

  typedef struct {
    logic [14:0][3:0] syms;
    int               len;
    int               lastpos;
    logic [15:0]      exp_s;
    logic             exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // General GF(2^4) multiply, shift-and-add over the bits of b.
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p = 4'h0;
    logic [3:0] aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gpow(input int e);
    logic [3:0] r = 4'h1;
    for (int i = 0; i < (e % 15); i++) r = gmul(r, 4'h2);
    return r;
  endfunction

  // S_j = sum_i r_i * alpha^(j*(len-1-i)), r_0 being the first symbol received.
  function automatic logic [15:0] model_syn(input logic [14:0][3:0] syms, input int len);
    logic [3:0] s[4];
    for (int j = 1; j <= 4; j++) begin
      s[j-1] = 4'h0;
      for (int i = 0; i < len; i++) s[j-1] ^= gmul(syms[i], gpow(j * (len - 1 - i)));
    end
    return {s[0], s[1], s[2], s[3]};
  endfunction

  task automatic feed(input logic [14:0][3:0] syms, input int len, input int lastpos,
                      input int bubbles);
    for (int i = 0; i < len; i++) begin
      int nb = bubbles ? $urandom_range(0, 2) : 0;
      for (int b = 0; b < nb; b++) begin
        sink_valid = 1'b0;
        sink_data  = 4'($urandom);
        sink_last  = 1'($urandom);
        tick();
      end
      chk("run_state", {30'd0, sink_ready, source_valid}, 32'h2);
      sink_valid = 1'b1;
      sink_data  = syms[i];
      sink_last  = (i == lastpos);
      tick();
    end
    sink_valid = 1'b0;
    sink_last  = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [15:0] exp_s, input logic exp_ferr);
    @(negedge sys_clk);
    chk({name, "_syn"}, {16'd0, s1, s2, s3, s4}, {16'd0, exp_s});
    chk({name, "_nz"}, {31'd0, source_nonzero}, {31'd0, |exp_s});
    chk({name, "_ferr"}, {31'd0, source_framing_err}, {31'd0, exp_ferr});
    chk({name, "_hs"}, {30'd0, sink_ready, source_valid}, 32'h1);
  endtask

  task automatic hold_release(input string name, input int cycles, input logic [15:0] exp_s,
                              input logic exp_ferr);
    for (int k = 0; k < cycles; k++) begin
      source_ready = 1'b0;
      sink_valid   = 1'($urandom);
      sink_data    = 4'($urandom);
      sink_last    = 1'($urandom);
      tick();
      check_out({name, "_hold"}, exp_s, exp_ferr);
    end
    sink_valid   = 1'b0;
    sink_last    = 1'b0;
    source_ready = 1'b1;
    tick();
    source_ready = 1'b0;
    @(negedge sys_clk);
    chk({name, "_rel_hs"}, {30'd0, sink_ready, source_valid}, 32'h2);
    chk({name, "_rel_clr"}, {27'd0, s1, source_framing_err}, 32'h0);
    chk({name, "_rel_clr2"}, {20'd0, s2, s3, s4}, 32'h0);
  endtask

  initial begin
    logic [14:0][3:0] syms;
    logic [15:0]      exp_s;
    int               len, lastpos;
    logic             exp_ferr;

    for (int v = 0; v < 7; v++) vecs[v].syms = '0;
    vecs[0].len = 15; vecs[0].lastpos = 14; vecs[0].exp_s = 16'h0000; vecs[0].exp_ferr = 1'b0;
    vecs[1].syms[14] = 4'h1;
    vecs[1].len = 15; vecs[1].lastpos = 14; vecs[1].exp_s = 16'h1111; vecs[1].exp_ferr = 1'b0;
    vecs[2].syms[0] = 4'h1;
    vecs[2].len = 15; vecs[2].lastpos = 14; vecs[2].exp_s = 16'h9DFE; vecs[2].exp_ferr = 1'b0;
    vecs[3].syms[9] = 4'h1;
    vecs[3].len = 10; vecs[3].lastpos = 9;  vecs[3].exp_s = 16'h1111; vecs[3].exp_ferr = 1'b1;
    vecs[4].syms[14] = 4'h1;
    vecs[4].len = 15; vecs[4].lastpos = -1; vecs[4].exp_s = 16'h1111; vecs[4].exp_ferr = 1'b1;
    vecs[5].syms[0] = 4'h5;
    vecs[5].len = 1;  vecs[5].lastpos = 0;  vecs[5].exp_s = 16'h5555; vecs[5].exp_ferr = 1'b1;
    vecs[6].syms[0] = 4'h1;
    vecs[6].len = 2;  vecs[6].lastpos = 1;  vecs[6].exp_s = 16'h2483; vecs[6].exp_ferr = 1'b1;

    sys_rst      = 1'b1;
    sink_valid   = 1'b0;
    sink_data    = 4'h0;
    sink_last    = 1'b0;
    source_ready = 1'b0;
    tick();
    tick();
    @(negedge sys_clk);
    chk("rst_hs", {30'd0, sink_ready, source_valid}, 32'h0);
    chk("rst_syn", {16'd0, s1, s2, s3, s4}, 32'h0);
    chk("rst_flags", {30'd0, source_nonzero, source_framing_err}, 32'h0);
    sys_rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      feed(vecs[v].syms, vecs[v].len, vecs[v].lastpos, 0);
      check_out($sformatf("vec%0d", v), vecs[v].exp_s, vecs[v].exp_ferr);
      hold_release($sformatf("vec%0d", v), (v == 2) ? 5 : 0, vecs[v].exp_s, vecs[v].exp_ferr);
    end

    // Reset in the middle of a codeword discards it completely.
    for (int i = 0; i < 15; i++) syms[i] = 4'($urandom_range(1, 15));
    feed(syms, 7, -1, 1);
    sys_rst    = 1'b1;
    sink_valid = 1'b1;
    sink_data  = 4'hF;
    @(negedge sys_clk);
    chk("midrst_hs", {30'd0, sink_ready, source_valid}, 32'h0);
    tick();
    sys_rst    = 1'b0;
    sink_valid = 1'b0;
    @(negedge sys_clk);
    chk("midrst_clr", {15'd0, s1, s2, s3, s4, source_framing_err}, 32'h0);
    chk("midrst_hs2", {30'd0, sink_ready, source_valid}, 32'h2);
    tick();
    feed('0, 15, 14, 0);
    check_out("after_rst", 16'h0000, 1'b0);

    // Reset while holding a result returns to RUN with cleared outputs.
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("outrst_hs", {30'd0, sink_ready, source_valid}, 32'h2);
    tick();

    for (int w = 0; w < 40; w++) begin
      len = $urandom_range(1, 15);
      lastpos = (len < 15 || $urandom_range(0, 1)) ? len - 1 : -1;
      for (int i = 0; i < 15; i++) syms[i] = 4'($urandom);
      exp_s    = model_syn(syms, len);
      exp_ferr = (len != 15) || (lastpos < 0);
      feed(syms, len, lastpos, 1);
      check_out($sformatf("rnd%0d", w), exp_s, exp_ferr);
      hold_release($sformatf("rnd%0d", w), $urandom_range(0, 3), exp_s, exp_ferr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_ctrl.md
RS_SYNDROME_CTRL -- requirements
Module: rs_syndrome_ctrl

Interface
REQ-001 SHALL have parameter N, default 15: codeword length in symbols, legal range 2..15.
REQ-002 SHALL have port sys_clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port sink_valid, input, 1: received symbol present on sink_data.
REQ-005 SHALL have port sink_ready, output, 1: block accepts a symbol this cycle.
REQ-006 SHALL have port sink_data, input, 4: received symbol in GF(2^4), highest-degree coefficient first.
REQ-007 SHALL have port sink_last, input, 1: marks the final symbol of a codeword.
REQ-008 SHALL have port source_valid, output, 1: syndrome result available.
REQ-009 SHALL have port source_ready, input, 1: consumer takes the result.
REQ-010 SHALL have ports s1, s2, s3, s4, output, 4 each: syndromes S_j = r(alpha^j).
REQ-011 SHALL have port source_nonzero, output, 1: OR-reduction of s1..s4.
REQ-012 SHALL have port source_framing_err, output, 1: codeword length did not match N.

Function
REQ-013 SHALL use GF(2^4) with primitive polynomial x^4+x+1, alpha = 4'h2; multiply-by-alpha is shift left one bit, then XOR 4'h3 if the shifted-out bit was 1.
REQ-014 SHALL use constant multipliers alpha^1=2, alpha^2=4, alpha^3=8, alpha^4=3; multiplication is purely combinational with no general multiplier.
REQ-015 SHALL implement a two-state FSM: RUN (sink_ready=1, source_valid=0) and OUT (sink_ready=0, source_valid=1).
REQ-016 SHALL define a symbol as accepted when sink_valid and sink_ready are both high on a clock edge.
REQ-017 SHALL, in RUN, on each accepted symbol, update S_j <= (S_j * alpha^j) XOR sink_data for j=1..4 (Horner) and increment a 4-bit symbol counter.
REQ-018 SHALL end a codeword on the accepted symbol where sink_last=1 or the counter equals N-1, whichever comes first, and go to OUT on the next edge.
REQ-019 SHALL latch source_framing_err=1 at codeword end if it is sink_last with counter != N-1, or counter == N-1 with sink_last=0; otherwise 0.
REQ-020 SHALL present the syndromes on s1..s4 in the cycle after the final symbol is accepted (latency 1).
REQ-021 SHALL hold s1..s4, source_nonzero and source_framing_err stable while in OUT with source_ready low.
REQ-022 SHALL, in OUT with source_ready=1, clear S_j, the counter and the framing flag to 0 and return to RUN on that edge.
REQ-023 SHALL ignore sink_valid, sink_data and sink_last while in OUT, with no state change.
REQ-024 SHALL leave state unchanged in RUN when sink_valid=0 (bubbles allowed mid-codeword).
REQ-025 SHALL not overlap codewords: minimum throughput is N+1 cycles per codeword with source_ready tied high.
REQ-026 SHALL drive source_nonzero combinationally from the registered s1..s4.

Reset
REQ-027 SHALL, while sys_rst=1 at an edge, set the FSM to RUN, set S1..S4=0, counter=0 and framing flag=0, regardless of the current state or a partially received codeword.
REQ-028 SHALL drive sink_ready=0 and source_valid=0 during any cycle in which sys_rst=1.
REQ-029 SHALL give s1..s4=0, source_nonzero=0 and source_framing_err=0 as reset output values.

Verification
REQ-030 SHALL check: 15 zero symbols, last on the 15th -> s1..s4=0, nonzero=0, framing_err=0, source_valid one cycle after the 15th accept.
REQ-031 SHALL check: 14 zeros then 4'h1 with last -> s1=s2=s3=s4=4'h1, nonzero=1.
REQ-032 SHALL check: 4'h1 then 14 zeros, last on the 15th -> s1=9, s2=D, s3=F, s4=E (hex).
REQ-033 SHALL check: sink_last on the 10th symbol -> OUT entered, framing_err=1; and 15 symbols with no last -> framing_err=1.
REQ-034 SHALL check: source_ready held low 5 cycles in OUT with sink_valid toggling -> outputs stable, sink_ready=0; release -> RUN the next cycle with cleared syndromes.
REQ-035 SHALL check: sys_rst pulsed after 7 symbols -> next codeword of 15 zeros gives all-zero syndromes, framing_err=0.
